// File: rtl/fetch_stage_pkg.sv
// Shared CPU-wide widths and encodings used by the fetch stage and its queue.
package fetch_stage_pkg;

    localparam int CPU_PC_W   = 12;
    localparam int CPU_INST_W = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [CPU_INST_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of {PC, instruction} pairs between instruction memory and decode.
// Flush empties the queue in one cycle and wins over a same-cycle push or pop.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = CPU_PC_W,
    parameter int INST_W = CPU_INST_W,
    parameter int QDEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [PC_W-1:0]          push_pc_i,
    input  logic [INST_W-1:0]        push_inst_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(QDEPTH):0]  count_o,
    output logic [PC_W-1:0]          head_pc_o,
    output logic [INST_W-1:0]        head_inst_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   pc_mem_q   [QDEPTH];
    logic [INST_W-1:0] inst_mem_q [QDEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            pc_mem_q[wr_ptr_q]   <= push_pc_i;
            inst_mem_q[wr_ptr_q] <= push_inst_i;
        end
    end

    assign count_o     = count_q;
    assign head_pc_o   = (count_q != '0) ? pc_mem_q[rd_ptr_q]   : '0;
    assign head_inst_o = (count_q != '0) ? inst_mem_q[rd_ptr_q] : INST_W'(NOP);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order memory requests, queues returned
// instructions for decode and squashes wrong-path fetches on a decode redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = CPU_PC_W,
    parameter int              INST_W   = CPU_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              stallD,
    input  logic              branchD,
    input  logic [PC_W-1:0]   PC_branch,
    output logic              validD,
    output logic [INST_W-1:0] instD,
    output logic [PC_W-1:0]   pcD
);

    localparam int          CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic              started_q;
    logic [CW-1:0]     q_count;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;
    logic              req_xfer, rsp_keep, q_valid, q_pop;

    // Queued plus in-flight instructions never exceed QDEPTH, so responses always fit.
    assign imem_req_valid = started_q && !reset && (({1'b0, q_count} + {1'b0, outst_q}) < QD);
    assign imem_req_addr  = pc_q;
    assign req_xfer       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard_q == '0);
    assign q_valid        = !reset && (q_count != '0);
    assign q_pop          = q_valid && !stallD;

    always_comb begin
        outst_d   = outst_q + CW'(req_xfer) - CW'(imem_rsp_valid);
        pc_d      = req_xfer ? pc_q + 1'b1 : pc_q;
        rsp_pc_d  = rsp_keep ? rsp_pc_q + 1'b1 : rsp_pc_q;
        discard_d = (imem_rsp_valid && (discard_q != '0)) ? discard_q - 1'b1 : discard_q;
        if (branchD) begin
            pc_d      = PC_branch;
            rsp_pc_d  = PC_branch;
            discard_d = outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            started_q <= 1'b1;
        end
    end

    fetch_queue #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (rsp_keep),
        .push_pc_i   (rsp_pc_q),
        .push_inst_i (imem_rsp_data),
        .pop_i       (q_pop),
        .flush_i     (branchD),
        .count_o     (q_count),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst)
    );

    assign validD = q_valid;
    assign instD  = q_valid ? head_inst : '0;
    assign pcD    = q_valid ? head_pc   : '0;

    rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (reset) imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus a queue-level reference of what decode should see.
module tb_fetch_stage;

    localparam int              PC_W    = 12;
    localparam int              INST_W  = 16;
    localparam int              QDEPTH  = 2;
    localparam logic [PC_W-1:0] RST_PC2 = 12'hFFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, req_ready, rsp_valid, stallD, branchD;
    logic [INST_W-1:0] rsp_data;
    logic [PC_W-1:0]   pc_branch;
    logic              req_valid, validD;
    logic [PC_W-1:0]   req_addr, pcD;
    logic [INST_W-1:0] instD;

    logic              rsp2_valid, req2_valid, valid2;
    logic [INST_W-1:0] rsp2_data, inst2;
    logic [PC_W-1:0]   req2_addr, pc2;

    fetch_stage #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(12'h000), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .stallD(stallD), .branchD(branchD), .PC_branch(pc_branch),
        .validD(validD), .instD(instD), .pcD(pcD));

    fetch_stage #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RST_PC2), .QDEPTH(QDEPTH)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req_valid(req2_valid), .imem_req_addr(req2_addr), .imem_req_ready(1'b1),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .stallD(1'b0), .branchD(1'b0), .PC_branch(12'h000),
        .validD(valid2), .instD(inst2), .pcD(pc2));

    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
    } req_t;

    req_t            pend[$];
    logic [PC_W-1:0] mq[$];
    logic [PC_W-1:0] dq[$];
    logic [PC_W-1:0] dq2[$];
    int              disc, lat, last_due, cyc, checks, errors, burst;
    logic [PC_W-1:0] m_pc, exp_pc, exp2, r2a, prev_addr, tgt_v;
    bit              m_started, r2v, prev_wait, last_valid, last_req;
    bit              rst_v, rdy_v, stall_v, br_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        req_t            r;
        bit              e_valid, e_req, rspv, s_req, s_req2, s_valid2;
        logic [PC_W-1:0] s_addr, s_addr2, hp;
        reset     = rst_v;
        req_ready = rdy_v;
        stallD    = stall_v;
        branchD   = br_v;
        pc_branch = tgt_v;
        rspv      = !rst_v && (pend.size() > 0) && (pend[0].due <= cyc);
        rsp_valid = rspv;
        rsp_data  = rspv ? {4'hA, pend[0].addr} : 16'h0000;
        rsp2_valid = !rst_v && r2v;
        rsp2_data  = {4'hA, r2a};
        #1;
        e_valid = !rst_v && (mq.size() > 0);
        hp = 12'h000;
        if (e_valid) hp = mq[0];
        e_req = !rst_v && m_started && ((mq.size() + pend.size()) < QDEPTH);
        chk("validD", validD, e_valid);
        chk("pcD", pcD, hp);
        chk("instD", instD, e_valid ? {4'hA, hp} : 16'h0000);
        chk("req_valid", req_valid, e_req);
        if (e_req) chk("req_addr", req_addr, m_pc);
        if (prev_wait && !rst_v) begin
            chk("hold_valid", req_valid, 1);
            chk("hold_addr", req_addr, prev_addr);
        end
        if (e_valid && (!stall_v || br_v)) begin
            chk("order", pcD, exp_pc);
            dq.push_back(pcD);
        end
        if (!rst_v && valid2) begin
            chk("dut2_pc", pc2, exp2);
            chk("dut2_inst", inst2, {4'hA, exp2});
            dq2.push_back(pc2);
        end
        s_req = req_valid; s_addr = req_addr;
        s_req2 = req2_valid; s_addr2 = req2_addr; s_valid2 = valid2;
        last_valid = validD; last_req = req_valid;
        @(posedge clk);
        if (rst_v) begin
            pend.delete(); mq.delete();
            disc = 0; m_pc = 12'h000; exp_pc = 12'h000; m_started = 0; last_due = cyc;
            r2v = 0; exp2 = RST_PC2; prev_wait = 0;
        end else begin
            m_started = 1;
            prev_wait = s_req && !rdy_v && !br_v;
            prev_addr = s_addr;
            if (s_req && rdy_v) begin
                r.addr = s_addr;
                r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = r.due;
                pend.push_back(r);
                m_pc = m_pc + 12'd1;
            end
            if (rspv) r = pend.pop_front();
            if (br_v) begin
                mq.delete();
                disc   = pend.size();
                m_pc   = tgt_v;
                exp_pc = tgt_v;
            end else begin
                if (e_valid && !stall_v) begin
                    void'(mq.pop_front());
                    exp_pc = exp_pc + 12'd1;
                end
                if (rspv) begin
                    if (disc > 0) disc--;
                    else mq.push_back(r.addr);
                end
            end
            if (s_valid2) exp2 = exp2 + 12'd1;
            r2v = s_req2;
            r2a = s_addr2;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_inputs(input bit allow_br);
        if (burst > 0) begin
            rdy_v = 0;
            burst--;
        end else begin
            rdy_v = 1;
            if ($urandom_range(0, 5) == 0) burst = $urandom_range(1, 4);
        end
        stall_v = ($urandom_range(0, 3) == 0);
        br_v    = allow_br && (mq.size() > 0) && ($urandom_range(0, 19) == 0);
        tgt_v   = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
    endtask

    initial begin
        int first_v, rel, n;
        checks = 0; errors = 0; cyc = 0; lat = 1; last_due = 0; disc = 0; burst = 0;
        m_pc = 12'h000; exp_pc = 12'h000; m_started = 0; exp2 = RST_PC2;
        r2v = 0; r2a = 12'h000; prev_wait = 0; prev_addr = 12'h000;
        rst_v = 1; rdy_v = 1; stall_v = 0; br_v = 0; tgt_v = 12'h000;
        reset = 1; req_ready = 1; rsp_valid = 0; rsp_data = '0; stallD = 0; branchD = 0;
        pc_branch = '0; rsp2_valid = 0; rsp2_data = '0;
        @(negedge clk);

        // Reset, then stream with a 1-cycle memory.
        repeat (3) step();
        rst_v = 0;
        rel = cyc;
        first_v = -1;
        for (int i = 0; i < 20; i++) begin
            n = cyc;
            step();
            if (last_valid && first_v < 0) first_v = n;
        end
        chk("first_valid_delay", first_v - rel, 3);
        if (dq2.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                logic [PC_W-1:0] e;
                e = RST_PC2 + 12'(i);
                chk("dut2_wrap_seq", dq2[i], e);
            end
        end else chk("dut2_len", dq2.size(), 4);

        // Decode stall fills the queue and throttles issue.
        stall_v = 1;
        repeat (6) step();
        chk("stall_req_drop", last_req, 0);
        chk("stall_valid_held", last_valid, 1);
        stall_v = 0;
        repeat (10) step();

        // Redirect to 040 with a slower memory.
        lat = 3;
        n = 0;
        while (mq.size() == 0 && n < 40) begin
            step();
            n++;
        end
        chk("branch_wait", mq.size() > 0, 1);
        br_v = 1; tgt_v = 12'h040;
        step();
        br_v = 0;
        dq.delete();
        repeat (15) step();
        if (dq.size() >= 2) begin
            chk("branch_first", dq[0], 12'h040);
            chk("branch_second", dq[1], 12'h041);
        end else chk("branch_deliveries", dq.size(), 2);

        // Random ready bursts, stalls and redirects.
        dq.delete();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1);
            step();
        end
        br_v = 0;
        chk("random_progress", dq.size() > 20, 1);

        // Reset mid-stream.
        rdy_v = 1; stall_v = 1; lat = 2;
        n = 0;
        while (mq.size() == 0 && n < 40) begin
            step();
            n++;
        end
        rst_v = 1;
        step();
        rst_v = 0; stall_v = 0;
        dq.delete();
        step();
        chk("reset_validD", last_valid, 0);
        for (int i = 0; i < 30; i++) begin
            rand_inputs(0);
            step();
        end
        if (dq.size() >= 1) chk("restart_pc", dq[0], 12'h000);
        else chk("restart_deliveries", dq.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
